rsa_exp_sequencer: RTL
======================

Name: rsa_exp_sequencer

Overview:
- Sequences one modular exponentiation on a single shared Montgomery multiplier (mmm_unit) using the right-to-left binary method.
- Issues one operation at a time: Montgomery-domain pre-conversion, per-bit multiply/square, post-conversion.
- The datapath owns the operand muxes and the P/R registers; this block only drives operation codes, start pulses and load strobes.
- Sits between the host command/register front-end and the multiplier datapath.

Parameters:
- WIDTH, 8, exponent width in bits.
- TIMEOUT, 64, maximum cycles to wait for mmm_done before aborting; must be >= WIDTH+4.

Ports:
- clk  input  1  clock
- rstb  input  1  synchronous active-low reset
- ena  input  1  clock enable; when low, all state and outputs hold
- clear  input  1  synchronous abort to IDLE
- start  input  1  begin exponentiation; sampled only in IDLE
- E  input  WIDTH  exponent; captured on the accepted start
- mmm_done  input  1  one-cycle completion pulse from the multiplier
- op_start  output  1  one-cycle pulse launching the multiplier
- op_sel  output  3  operand/destination code: 0 PRE_P, 1 PRE_R, 2 MUL, 3 SQR, 4 POST
- ld_p  output  1  load multiplier result into P register
- ld_r  output  1  load multiplier result into R register
- busy  output  1  exponentiation in progress
- eoc  output  1  one-cycle end-of-computation pulse
- err  output  1  sticky timeout flag
- bit_idx  output  $clog2(WIDTH)  index of the exponent bit being processed

Behaviour:
- Single clock. Reset is synchronous, active-low, on rstb. Priority: rstb > clear > ena.
- Reset values: all outputs 0; state IDLE; exponent shift register 0; timeout counter 0.
- clear (with rstb high): next state IDLE, busy=0, op_start/ld_*/eoc=0. err and bit_idx keep their values. clear is honoured even when ena is low.
- Operation semantics, listed for verification; the datapath implements them:
  - PRE_P: P <- MMM(Const, P_in)
  - PRE_R: R <- MMM(Const, 1)
  - MUL: R <- MMM(R, P)
  - SQR: P <- MMM(P, P)
  - POST: R <- MMM(R, 1)
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start=1: capture E into exp_sh, bit_idx=0, err=0, busy=1.
  - First op is PRE_P, or PRE_R if E==0.
  - Go to ISSUE.
- ISSUE: op_start=1 for exactly one cycle, op_sel=current op; clear the timeout counter; go to WAIT.
- WAIT:
  - op_sel holds its value.
  - mmm_done=1: assert ld_p (PRE_P, SQR) or ld_r (PRE_R, MUL, POST) combinationally in the same cycle. Select the next op, then go to ISSUE (or DONE after POST).
  - mmm_done is ignored outside WAIT, including the ISSUE cycle.
- Next-op rules:
  - PRE_P -> PRE_R.
  - PRE_R -> POST if exp_sh==0; else MUL if exp_sh[0]=1; else SQR.
  - MUL -> POST if (exp_sh>>1)==0; else SQR.
  - SQR -> shift exp_sh right by 1 and increment bit_idx; next is MUL if the new exp_sh[0]=1, else SQR.
- Consequence: no square is issued past the highest set bit, and no zero-bit work happens once the remaining exponent is zero.
- DONE: eoc=1 for one cycle, busy=0, go to IDLE. busy falls in the same cycle eoc rises.
- Timeout:
  - The counter increments each enabled WAIT cycle.
  - If it reaches TIMEOUT without mmm_done: err=1 (sticky until the next accepted start), busy=0, no eoc, go to IDLE.
- start while busy is ignored.
- Operation counts:
  - E=0: 2 ops.
  - Otherwise: 3 + popcount(E) + position of the MSB set (ops).
- ena low: the FSM, counters and the exp_sh register freeze, and pulse outputs are forced to 0. A mmm_done arriving while ena is low is lost.

Test Plan:
- Reset mid-WAIT (rstb=0 for 1 cycle) -> all outputs 0, state IDLE; a new start then works normally.
- E=0, start, mmm_done 5 cycles after each op_start -> op_sel sequence 1,4; two ld_r pulses; eoc once; busy high until the eoc cycle.
- E=8'b0000_0101 -> op_sel 0,1,2,3,3,2,4 (7 op_start pulses); ld_p on the ops with code 0 and 3, ld_r on the rest; bit_idx ends at 2.
- E=8'hFF -> 18 ops, alternating MUL/SQR with a final MUL then POST; bit_idx ends at 7. E=8'h80 -> 0,1, seven SQR, 2,4 (11 ops).
- mmm_done never returns after the third op_start, TIMEOUT=64 -> err=1 exactly 64 enabled cycles into WAIT, busy=0, no eoc; the next start clears err.
- During WAIT: ena low for 10 cycles (state holds), clear asserted (-> IDLE, no eoc), start asserted while busy (ignored), and mmm_done pulsed in an ISSUE cycle (ignored, no ld_*).

Source files
------------

// File: rtl/rsa_exp_sequencer.sv
// Right-to-left binary modular exponentiation sequencer driving one shared
// Montgomery multiplier: issues opcodes and start pulses, and steers result loads into P/R.
module rsa_exp_sequencer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       ena,
  input  logic                       clear,
  input  logic                       start,
  input  logic [WIDTH-1:0]           E,
  input  logic                       mmm_done,
  output logic                       op_start,
  output logic [2:0]                 op_sel,
  output logic                       ld_p,
  output logic                       ld_r,
  output logic                       busy,
  output logic                       eoc,
  output logic                       err,
  output logic [$clog2(WIDTH)-1:0]   bit_idx
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_PRE_P = 3'd0,
    OP_PRE_R = 3'd1,
    OP_MUL   = 3'd2,
    OP_SQR   = 3'd3,
    OP_POST  = 3'd4
  } op_t;

  state_t           r_state, w_state_nx;
  op_t              r_op, w_op_nx;
  logic [WIDTH-1:0] r_exp, w_exp_nx, w_exp_shr;
  logic [IW-1:0]    r_idx, w_idx_nx;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic             r_err, w_err_nx;
  logic             r_busy, w_busy_nx;
  logic             w_op_start, w_ld_p, w_ld_r, w_eoc;
  logic             w_act;

  // Next-state, next-operation selection and raw pulse generation
  always_comb begin
    w_state_nx = r_state;
    w_op_nx    = r_op;
    w_exp_nx   = r_exp;
    w_idx_nx   = r_idx;
    w_cnt_nx   = r_cnt;
    w_err_nx   = r_err;
    w_busy_nx  = r_busy;
    w_op_start = 1'b0;
    w_ld_p     = 1'b0;
    w_ld_r     = 1'b0;
    w_eoc      = 1'b0;
    w_exp_shr  = r_exp >> 1;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_exp_nx   = E;
          w_idx_nx   = '0;
          w_err_nx   = 1'b0;
          w_busy_nx  = 1'b1;
          w_op_nx    = (E == '0) ? OP_PRE_R : OP_PRE_P;
          w_state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_op_start = 1'b1;
        w_cnt_nx   = '0;
        w_state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (mmm_done) begin
          w_state_nx = S_ISSUE;
          case (r_op)
            OP_PRE_P: begin
              w_ld_p  = 1'b1;
              w_op_nx = OP_PRE_R;
            end
            OP_PRE_R: begin
              w_ld_r = 1'b1;
              if (r_exp == '0)    w_op_nx = OP_POST;
              else if (r_exp[0])  w_op_nx = OP_MUL;
              else                w_op_nx = OP_SQR;
            end
            OP_MUL: begin
              w_ld_r  = 1'b1;
              w_op_nx = (w_exp_shr == '0) ? OP_POST : OP_SQR;
            end
            OP_SQR: begin
              // Squaring consumes the current bit: advance to the next one
              w_ld_p   = 1'b1;
              w_exp_nx = w_exp_shr;
              w_idx_nx = r_idx + IW'(1);
              w_op_nx  = w_exp_shr[0] ? OP_MUL : OP_SQR;
            end
            OP_POST: begin
              w_ld_r     = 1'b1;
              w_busy_nx  = 1'b0;
              w_state_nx = S_DONE;
            end
            default: begin
              w_busy_nx  = 1'b0;
              w_state_nx = S_IDLE;
            end
          endcase
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_err_nx   = 1'b1;
          w_busy_nx  = 1'b0;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_eoc      = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: begin
        w_busy_nx  = 1'b0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State registers: reset beats clear, clear beats the clock enable
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state <= S_IDLE;
      r_op    <= OP_PRE_P;
      r_exp   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (ena) begin
      r_state <= w_state_nx;
      r_op    <= w_op_nx;
      r_exp   <= w_exp_nx;
      r_idx   <= w_idx_nx;
      r_cnt   <= w_cnt_nx;
      r_err   <= w_err_nx;
      r_busy  <= w_busy_nx;
    end
  end

  // Pulses only fire on cycles that actually advance the FSM
  assign w_act    = rstb & ~clear & ena;
  assign op_start = w_act & w_op_start;
  assign ld_p     = w_act & w_ld_p;
  assign ld_r     = w_act & w_ld_r;
  assign eoc      = w_act & w_eoc;
  assign op_sel   = r_op;
  assign busy     = r_busy;
  assign err      = r_err;
  assign bit_idx  = r_idx;

endmodule
